// File: rtl/fp_mag_addsub_pipe_pkg.sv
// ----------------------------------------------------------------------------
// fp_mag_addsub_pipe_pkg
// Shared constants and helpers for the FP magnitude add/sub pipeline.
//   - Default half-precision field widths.
//   - Bit positions of the result flag vector.
//   - Round-to-nearest-even increment decision.
//   - Exponent bias / all-ones helpers.
// No ports (package).
// ----------------------------------------------------------------------------
package fp_mag_addsub_pipe_pkg;

    localparam int DEF_EXP_W  = 5;
    localparam int DEF_FRAC_W = 10;

    localparam int FLAG_W       = 5;
    localparam int FLAG_ZERO    = 4;
    localparam int FLAG_SUBN    = 3;
    localparam int FLAG_UF      = 2;
    localparam int FLAG_OF      = 1;
    localparam int FLAG_INEXACT = 0;

    // Round up when the guard bit is set and the value is either above the
    // halfway point (R or S set) or exactly halfway with an odd LSB.
    function automatic logic rne_round_up(input logic lsb, input logic g,
                                          input logic r, input logic s);
        return g && (r || s || lsb);
    endfunction

    function automatic int exp_all_ones(input int expW);
        return (1 << expW) - 1;
    endfunction

    function automatic int exp_bias(input int expW);
        return (1 << (expW - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_mag_addsub_pipe_lzc.sv
// ----------------------------------------------------------------------------
// fp_mag_addsub_pipe_lzc
// Priority leading-zero counter used by the normalisation stage.
// Ports:
//   i_value  in   W    vector to scan, MSB first
//   o_count  out  CW   number of zeros above the first set bit (W if all zero)
// ----------------------------------------------------------------------------
module fp_mag_addsub_pipe_lzc
    import fp_mag_addsub_pipe_pkg::*;
#(
    parameter int W  = 14,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_value,
    output logic [CW-1:0] o_count
);

    // Scan from LSB upward so the highest set bit is the last one written.
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_value[i]) begin
                o_count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_mag_addsub_pipe.sv
// ----------------------------------------------------------------------------
// fp_mag_addsub_pipe
// Three-stage pipelined magnitude add/sub of exponent-aligned operands with
// normalisation, round-to-nearest-even and IEEE packing with status flags.
// Stage 1 adds/subtracts, stage 2 normalises, stage 3 rounds and packs.
// Ports:
//   i_clk        in   1           clock, rising edge
//   i_rst        in   1           synchronous active-high reset
//   i_in_valid   in   1           operand beat valid
//   o_in_ready   out  1           stage accepts a beat this cycle
//   i_op         in   1           0 = A+B, 1 = A-B
//   i_sign_a     in   1           sign of A
//   i_sign_b     in   1           sign of B before i_op
//   i_in_exp     in   EXP_W       common biased exponent (0 = subnormal)
//   i_in_mant_a  in   MW          {hidden,frac,G,R,S}, already aligned
//   i_in_mant_b  in   MW          same format as A
//   o_out_valid  out  1           result valid
//   i_out_ready  in   1           downstream accepts the result
//   o_q          out  QW          packed {sign,exp,frac}
//   o_flags      out  5           {ZERO,SUBN,UF,OF,INEXACT}
// ----------------------------------------------------------------------------
module fp_mag_addsub_pipe
    import fp_mag_addsub_pipe_pkg::*;
#(
    parameter  int EXP_W  = DEF_EXP_W,
    parameter  int FRAC_W = DEF_FRAC_W,
    localparam int MW     = FRAC_W + 4,
    localparam int QW     = 1 + EXP_W + FRAC_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_op,
    input  logic              i_sign_a,
    input  logic              i_sign_b,
    input  logic [EXP_W-1:0]  i_in_exp,
    input  logic [MW-1:0]     i_in_mant_a,
    input  logic [MW-1:0]     i_in_mant_b,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [QW-1:0]     o_q,
    output logic [FLAG_W-1:0] o_flags
);

    // Two spare exponent bits cover the carry increment and the rounding
    // increment on top of the largest legal input exponent.
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MW + 1);
    localparam int SW = FRAC_W + 2;
    localparam logic [EW-1:0] EXP_MAX = EW'(exp_all_ones(EXP_W));

    logic r_v1, r_v2, r_v3;
    logic w_ld1, w_ld2, w_ld3;

    logic              r_sign1;
    logic [EW-1:0]     r_exp1;
    logic [MW:0]       r_mant1;
    logic              r_sign2;
    logic [EW-1:0]     r_exp2;
    logic [MW-1:0]     r_mant2;
    logic [QW-1:0]     r_q;
    logic [FLAG_W-1:0] r_flags;

    // Each stage loads when it is empty or its successor is loading, so a
    // full pipe under continuous ready still moves one beat per cycle.
    assign w_ld3       = !r_v3 || i_out_ready;
    assign w_ld2       = !r_v2 || w_ld3;
    assign w_ld1       = !r_v1 || w_ld2;
    assign o_in_ready  = w_ld1;
    assign o_out_valid = r_v3;
    assign o_q         = r_q;
    assign o_flags     = r_flags;

    // ---------------- Stage 1: effective add / subtract ----------------
    logic          w_effSub, w_signB, w_aGeB, w_sign1;
    logic [EW-1:0] w_exp1;
    logic [MW:0]   w_mant1;

    // Subtraction always produces a non-negative magnitude by ordering the
    // operands; exact cancellation is forced to +0.
    always_comb begin
        w_effSub = i_sign_a ^ i_sign_b ^ i_op;
        w_signB  = i_sign_b ^ i_op;
        w_aGeB   = (i_in_mant_a >= i_in_mant_b);
        w_exp1   = (i_in_exp == '0) ? EW'(1) : EW'(i_in_exp);
        w_mant1  = {1'b0, i_in_mant_a} + {1'b0, i_in_mant_b};
        w_sign1  = i_sign_a;
        if (w_effSub) begin
            if (w_aGeB) begin
                w_mant1 = {1'b0, i_in_mant_a} - {1'b0, i_in_mant_b};
                w_sign1 = (i_in_mant_a == i_in_mant_b) ? 1'b0 : i_sign_a;
            end else begin
                w_mant1 = {1'b0, i_in_mant_b} - {1'b0, i_in_mant_a};
                w_sign1 = w_signB;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1 <= 1'b0;
        end else if (w_ld1) begin
            r_v1 <= i_in_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_ld1 && i_in_valid) begin
            r_sign1 <= w_sign1;
            r_exp1  <= w_exp1;
            r_mant1 <= w_mant1;
        end
    end

    // ---------------- Stage 2: normalise ----------------
    logic [CW-1:0] w_lz;
    logic [EW-1:0] w_lzExt, w_shMax, w_shift, w_exp2;
    logic [MW-1:0] w_mant2;

    fp_mag_addsub_pipe_lzc #(.W(MW), .CW(CW)) u_lzc (
        .i_value (r_mant1[MW-1:0]),
        .o_count (w_lz)
    );

    // Left shift stops at exponent 1 so tiny results land in the subnormal
    // encoding; a carry out instead shifts right keeping the lost bit sticky.
    always_comb begin
        w_lzExt = EW'(w_lz);
        w_shMax = r_exp1 - EW'(1);
        w_shift = (w_lzExt < w_shMax) ? w_lzExt : w_shMax;
        w_mant2 = r_mant1[MW-1:0] << w_shift;
        w_exp2  = r_exp1 - w_shift;
        if (r_mant1[MW]) begin
            w_mant2 = {r_mant1[MW:2], r_mant1[1] | r_mant1[0]};
            w_exp2  = r_exp1 + EW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v2 <= 1'b0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_ld2 && r_v1) begin
            r_sign2 <= r_sign1;
            r_exp2  <= w_exp2;
            r_mant2 <= w_mant2;
        end
    end

    // ---------------- Stage 3: round and pack ----------------
    logic              w_g, w_r, w_s, w_inexact, w_up, w_tiny, w_of;
    logic [SW-1:0]     w_sum;
    logic [EW-1:0]     w_expR;
    logic [FRAC_W-1:0] w_frac;
    logic [QW-1:0]     w_q;
    logic [FLAG_W-1:0] w_flags;

    // A hidden bit of zero after rounding means the exponent field is 0;
    // a subnormal that rounds up into the hidden bit becomes the smallest
    // normal naturally because its working exponent is already 1.
    always_comb begin
        w_g       = r_mant2[2];
        w_r       = r_mant2[1];
        w_s       = r_mant2[0];
        w_inexact = w_g | w_r | w_s;
        w_up      = rne_round_up(r_mant2[3], w_g, w_r, w_s);
        w_sum     = {1'b0, r_mant2[MW-1:3]} + SW'(w_up);
        w_tiny    = !r_mant2[MW-1];
        w_frac    = w_sum[FRAC_W-1:0];
        w_expR    = w_sum[FRAC_W] ? r_exp2 : '0;
        if (w_sum[SW-1]) begin
            w_expR = r_exp2 + EW'(1);
            w_frac = '0;
        end
        w_of    = (w_expR >= EXP_MAX);
        w_flags = '0;
        if (w_of) begin
            w_q                   = {r_sign2, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_flags[FLAG_OF]      = 1'b1;
            w_flags[FLAG_INEXACT] = 1'b1;
        end else begin
            w_q                   = {r_sign2, w_expR[EXP_W-1:0], w_frac};
            w_flags[FLAG_ZERO]    = (w_expR == '0) && (w_frac == '0);
            w_flags[FLAG_SUBN]    = (w_expR == '0) && (w_frac != '0);
            w_flags[FLAG_UF]      = w_tiny && w_inexact;
            w_flags[FLAG_INEXACT] = w_inexact;
        end
    end

    // Output registers only change when the downstream side can take a new
    // result, which keeps Q and FLAGS frozen during a stall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v3    <= 1'b0;
            r_q     <= '0;
            r_flags <= '0;
        end else if (w_ld3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_q     <= w_q;
                r_flags <= w_flags;
            end
        end
    end

    // Infinity/NaN exponents must be resolved upstream before reaching here.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_in_valid && w_ld1) begin
            assert (i_in_exp != {EXP_W{1'b1}});
        end
    end

endmodule

// File: tb/tb_fp_mag_addsub_pipe.sv
// ----------------------------------------------------------------------------
// tb_fp_mag_addsub_pipe
// Self-checking bench for the half-precision configuration. Expected results
// come from a value-based reference model: the exact magnitude is computed
// as an integer, then quantised to the destination format with RNE.
// ----------------------------------------------------------------------------
module tb_fp_mag_addsub_pipe;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int MW     = FRAC_W + 4;
    localparam int QW     = 1 + EXP_W + FRAC_W;
    localparam int K      = FRAC_W + 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             inValid = 1'b0;
    logic             inReady;
    logic             op = 1'b0;
    logic             signA = 1'b0;
    logic             signB = 1'b0;
    logic [EXP_W-1:0] inExp = '0;
    logic [MW-1:0]    mantA = '0;
    logic [MW-1:0]    mantB = '0;
    logic             outValid;
    logic             outReady = 1'b1;
    logic [QW-1:0]    q;
    logic [4:0]       flags;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    fp_mag_addsub_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_op        (op),
        .i_sign_a    (signA),
        .i_sign_b    (signB),
        .i_in_exp    (inExp),
        .i_in_mant_a (mantA),
        .i_in_mant_b (mantB),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_q         (q),
        .o_flags     (flags)
    );

    // Reference: exact integer magnitude in units of the input LSB, placed at
    // the destination exponent, then rounded with plain integer arithmetic.
    function automatic logic [QW+4:0] refModel(input logic sa, input logic sb,
                                               input logic o, input int ex,
                                               input int ma, input int mb);
        int e0, mag, p, e, d, n, rem, half, expField;
        logic sgn, effSub, inexact, tiny;
        logic [QW-1:0] rq;
        logic [4:0] rf;
        e0 = (ex == 0) ? 1 : ex;
        effSub = sa ^ sb ^ o;
        if (!effSub) begin
            mag = ma + mb; sgn = sa;
        end else if (ma >= mb) begin
            mag = ma - mb; sgn = sa;
        end else begin
            mag = mb - ma; sgn = sb ^ o;
        end
        if (mag == 0) begin
            rq = effSub ? '0 : {sgn, {(QW-1){1'b0}}};
            rf = 5'b10000;
            return {rq, rf};
        end
        p = 0;
        for (int i = 0; i < 31; i++) if (((mag >> i) & 1) == 1) p = i;
        e = e0 + p - K;
        tiny = (e < 1);
        if (tiny) e = 1;
        d = e - e0 + 3;
        if (d > 0) begin
            n = mag >> d;
            rem = mag & ((1 << d) - 1);
            half = 1 << (d - 1);
            inexact = (rem != 0);
            if ((rem > half) || ((rem == half) && ((n % 2) == 1))) n = n + 1;
        end else begin
            n = mag << (-d);
            inexact = 1'b0;
        end
        if (n >= (1 << (FRAC_W + 1))) begin
            n = n >> 1; e = e + 1;
        end
        expField = (n >= (1 << FRAC_W)) ? e : 0;
        if (expField >= (1 << EXP_W) - 1) begin
            rq = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            rf = 5'b00011;
        end else begin
            rq = {sgn, expField[EXP_W-1:0], n[FRAC_W-1:0]};
            rf[4] = (expField == 0) && (n[FRAC_W-1:0] == 0);
            rf[3] = (expField == 0) && (n[FRAC_W-1:0] != 0);
            rf[2] = tiny && inexact;
            rf[1] = 1'b0;
            rf[0] = inexact;
        end
        return {rq, rf};
    endfunction

    task automatic applyStimulus(input logic sa, input logic sb, input logic o,
                                 input logic [EXP_W-1:0] ex,
                                 input logic [MW-1:0] a, input logic [MW-1:0] b);
        signA = sa; signB = sb; op = o; inExp = ex; mantA = a; mantB = b;
        inValid = 1'b1;
    endtask

    task automatic randomBeat();
        logic [MW-1:0] a, b;
        int ex;
        ex = $urandom_range(0, 30);
        a = MW'($urandom);
        a[MW-1] = (ex != 0);
        case ($urandom_range(0, 2))
            0:       b = a >> $urandom_range(0, MW);
            1:       b = a ^ MW'($urandom_range(0, 15));
            default: b = MW'($urandom);
        endcase
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), EXP_W'(ex), a, b);
    endtask

    // Sends the already-applied beat into an empty pipe and waits (bounded)
    // for its result; latency is counted in sampled cycles after acceptance.
    task automatic sendOne(output logic [QW-1:0] qOut, output logic [4:0] fOut,
                           output int lat);
        outReady = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        lat = 0; qOut = '0; fOut = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (outValid) begin
                lat = i; qOut = q; fOut = flags;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inValid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkCount++;
        if (outValid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%0b expected=0", outValid);
        else passCount++;
        checkCount++;
        if (q !== '0) $display("[TB] FAIL reset_q got=%h expected=0000", q);
        else passCount++;
        checkCount++;
        if (flags !== '0) $display("[TB] FAIL reset_flags got=%b expected=00000", flags);
        else passCount++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkCount++;
        if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready got=%0b expected=1", inReady);
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic          vSa[7], vSb[7], vOp[7];
        logic [4:0]    vEx[7];
        logic [MW-1:0] vA[7], vB[7];
        logic [QW-1:0] vQ[7];
        logic [4:0]    vF[7];
        logic [QW-1:0] qOut;
        logic [4:0]    fOut;
        int            lat;
        vSa = '{0, 0, 0, 0, 0, 0, 0};
        vSb = '{0, 0, 0, 0, 0, 0, 0};
        vOp = '{0, 1, 0, 0, 0, 1, 1};
        vEx = '{15, 15, 30, 15, 15, 1, 15};
        vA  = '{14'h2000, 14'h2000, 14'h3FF8, 14'h2004, 14'h200C, 14'h2000, 14'h2000};
        vB  = '{14'h2000, 14'h2000, 14'h3FF8, 14'h0000, 14'h0000, 14'h1FF8, 14'h3000};
        vQ  = '{16'h4000, 16'h0000, 16'h7C00, 16'h3C00, 16'h3C02, 16'h0001, 16'hB800};
        vF  = '{5'b00000, 5'b10000, 5'b00011, 5'b00001, 5'b00001, 5'b01000, 5'b00000};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vSa[i], vSb[i], vOp[i], vEx[i], vA[i], vB[i]);
            sendOne(qOut, fOut, lat);
            checkCount++;
            if (lat !== 3) $display("[TB] FAIL directed%0d_latency got=%0d expected=3", i, lat);
            else passCount++;
            checkCount++;
            if (qOut !== vQ[i]) $display("[TB] FAIL directed%0d_q got=%h expected=%h", i, qOut, vQ[i]);
            else passCount++;
            checkCount++;
            if (fOut !== vF[i]) $display("[TB] FAIL directed%0d_flags got=%b expected=%b", i, fOut, vF[i]);
            else passCount++;
        end
    endtask

    task automatic test_random();
        logic [QW+4:0] expQ[$];
        logic [QW+4:0] expv;
        int sent = 0, got = 0, cyc = 0;
        int nBeats = 200;
        while ((got < nBeats) && (cyc < 4000)) begin
            cyc++;
            outReady = ($urandom_range(0, 3) != 0);
            if ((sent < nBeats) && ($urandom_range(0, 4) != 0)) randomBeat();
            else inValid = 1'b0;
            @(negedge clk);
            if (outValid && outReady) begin
                checkCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL random_extra got=%h/%b expected=no result", q, flags);
                end else begin
                    expv = expQ.pop_front();
                    if ({q, flags} !== expv)
                        $display("[TB] FAIL random_result got=%h/%b expected=%h/%b",
                                 q, flags, expv[QW+4:5], expv[4:0]);
                    else passCount++;
                end
                got++;
            end
            if (inValid && inReady) begin
                expQ.push_back(refModel(signA, signB, op, int'(inExp), int'(mantA), int'(mantB)));
                sent++;
            end
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        checkCount++;
        if (got != nBeats) $display("[TB] FAIL random_count got=%0d expected=%0d", got, nBeats);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [QW+4:0] expQ[$];
        logic [QW+4:0] expv, heldVal;
        logic stallPrev = 1'b0;
        bit sawReadyLow = 0;
        int sent = 0, got = 0, cyc = 0;
        heldVal = '0;
        while ((got < 8) && (cyc < 100)) begin
            cyc++;
            outReady = !((cyc >= 4) && (cyc <= 8));
            if (sent < 8) randomBeat();
            else inValid = 1'b0;
            @(negedge clk);
            if (inValid && !inReady) sawReadyLow = 1;
            if (stallPrev) begin
                checkCount++;
                if (!outValid || ({q, flags} !== heldVal))
                    $display("[TB] FAIL b2b_hold got=%0b/%h/%b expected=1/%h/%b",
                             outValid, q, flags, heldVal[QW+4:5], heldVal[4:0]);
                else passCount++;
            end
            stallPrev = 1'b0;
            if (outValid && outReady) begin
                checkCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL b2b_extra got=%h/%b expected=no result", q, flags);
                end else begin
                    expv = expQ.pop_front();
                    if ({q, flags} !== expv)
                        $display("[TB] FAIL b2b_result%0d got=%h/%b expected=%h/%b",
                                 got, q, flags, expv[QW+4:5], expv[4:0]);
                    else passCount++;
                end
                got++;
            end else if (outValid) begin
                stallPrev = 1'b1;
                heldVal = {q, flags};
            end
            if (inValid && inReady) begin
                expQ.push_back(refModel(signA, signB, op, int'(inExp), int'(mantA), int'(mantB)));
                sent++;
            end
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        outReady = 1'b1;
        checkCount++;
        if (got != 8) $display("[TB] FAIL b2b_count got=%0d expected=8", got);
        else passCount++;
        checkCount++;
        if (!sawReadyLow) $display("[TB] FAIL b2b_in_ready_drop got=0 expected=1");
        else passCount++;
    endtask

    task automatic test_reset_midstream();
        bit sawOut = 0;
        outReady = 1'b1;
        repeat (2) begin
            randomBeat();
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkCount++;
        if (outValid !== 1'b0) $display("[TB] FAIL midreset_out_valid got=%0b expected=0", outValid);
        else passCount++;
        checkCount++;
        if (q !== '0) $display("[TB] FAIL midreset_q got=%h expected=0000", q);
        else passCount++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkCount++;
        if (inReady !== 1'b1) $display("[TB] FAIL midreset_in_ready got=%0b expected=1", inReady);
        else passCount++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (outValid) sawOut = 1;
        end
        checkCount++;
        if (sawOut) $display("[TB] FAIL midreset_no_output got=1 expected=0");
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
